// File: rtl/score_pkg.sv
// Shared definitions for the score counter slice.
// Holds the BCD digit type, the active-low 7-segment codes (gfedcba)
// for decimal digits 0..9, and the all-segments-off blank code.
package score_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd - 4-bit BCD digit (0..9)
//   seg - active-low segments, bit order gfedcba
// Codes 10..15 never occur in the counter; they decode to blank.
module seg7_decode
    import score_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_counter.sv
// Multi-digit BCD score counter with best-score register and 7-seg outputs.
// Parameters:
//   DIGITS   - number of BCD digits (1..6)
//   SATURATE - 0: wrap to zero past all nines, 1: hold at all nines
//   BLANK_LZ - 1: blank digits above the most significant nonzero digit
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset of count, best and new_best
//   score     - +1 to the count for every cycle it is high
//   clear     - synchronous clear of the current count
//   game_over - commit current count to best if strictly greater
//   hex_cur   - active-low 7-seg of current count, [0] = least significant
//   hex_best  - active-low 7-seg of best count
//   overflow  - combinational, score with count at all nines (no clear)
//   new_best  - one-cycle pulse the cycle after best was raised
module score_counter
    import score_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   score,
    input  logic                   clear,
    input  logic                   game_over,
    output logic [DIGITS-1:0][6:0] hex_cur,
    output logic [DIGITS-1:0][6:0] hex_best,
    output logic                   overflow,
    output logic                   new_best
);

    bcd_t cur_p0  [DIGITS];
    bcd_t best_p0 [DIGITS];

    logic [DIGITS-1:0] is_nine;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] cur_gt;
    logic [DIGITS-1:0] cur_eq;
    logic [DIGITS-1:0] cur_nz;
    logic [DIGITS-1:0] best_nz;
    logic [DIGITS-1:0] show_cur;
    logic [DIGITS-1:0] show_best;
    logic              all_nines;
    logic              cur_greater;
    logic              hold;
    logic              raise_best;

    // Ripple increment: digit i steps when score is high and every lower
    // digit is at nine.
    always_comb begin
        logic run;
        run   = score;
        carry = '0;
        for (int i = 0; i < DIGITS; i++) begin
            carry[i] = run;
            run      = run & is_nine[i];
        end
    end

    assign all_nines = &is_nine;
    assign overflow  = score & ~clear & all_nines;
    assign hold      = SATURATE && all_nines;

    // Magnitude compare from the least significant digit up: a higher digit
    // decides unless it is equal, in which case the lower digits decide.
    always_comb begin
        logic gt;
        gt = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            gt = cur_gt[i] | (cur_eq[i] & gt);
        end
        cur_greater = gt;
    end

    assign raise_best = game_over & cur_greater;

    // A digit is shown if it is the units digit, or some digit at or above
    // it is nonzero, or leading-zero blanking is disabled.
    always_comb begin
        logic nz_c;
        logic nz_b;
        nz_c      = 1'b0;
        nz_b      = 1'b0;
        show_cur  = '0;
        show_best = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_c         = nz_c | cur_nz[i];
            nz_b         = nz_b | best_nz[i];
            show_cur[i]  = !BLANK_LZ || (i == 0) || nz_c;
            show_best[i] = !BLANK_LZ || (i == 0) || nz_b;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            logic [6:0] seg_cur;
            logic [6:0] seg_best;

            assign is_nine[g] = (cur_p0[g] == BCD_NINE);
            assign cur_gt[g]  = (cur_p0[g] > best_p0[g]);
            assign cur_eq[g]  = (cur_p0[g] == best_p0[g]);
            assign cur_nz[g]  = (cur_p0[g] != '0);
            assign best_nz[g] = (best_p0[g] != '0);

            // Best captures the registered (pre-increment, pre-clear) count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cur_p0[g]  <= '0;
                    best_p0[g] <= '0;
                end else begin
                    if (clear) begin
                        cur_p0[g] <= '0;
                    end else if (carry[g] && !hold) begin
                        cur_p0[g] <= is_nine[g] ? 4'd0 : cur_p0[g] + 4'd1;
                    end
                    if (raise_best) begin
                        best_p0[g] <= cur_p0[g];
                    end
                end
            end

            seg7_decode u_dec_cur (
                .bcd (cur_p0[g]),
                .seg (seg_cur)
            );

            seg7_decode u_dec_best (
                .bcd (best_p0[g]),
                .seg (seg_best)
            );

            assign hex_cur[g]  = show_cur[g]  ? seg_cur  : SEG_BLANK;
            assign hex_best[g] = show_best[g] ? seg_best : SEG_BLANK;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_best <= 1'b0;
        end else begin
            new_best <= raise_best;
        end
    end

endmodule
